microwave_timer: RTL



---
 rtl/timer_pkg.sv | 30 +++
 rtl/mmss_dec.sv | 35 +++
 rtl/microwave_timer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave countdown timer.
// Pure declarations; no clocked logic, so no latency or flow control applies.
package timer_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] digit_t;

   localparam digit_t BCD_MAX       = 4'd9;
   localparam digit_t SEC_TENS_WRAP = 4'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      digit_t min_tens;
      digit_t min_units;
      digit_t sec_tens;
      digit_t sec_units;
   } mmss_t;

   function automatic logic is_zero(input mmss_t t);
      return (t == '0);
   endfunction

endpackage

// File: rtl/mmss_dec.sv
// Combinational MM:SS BCD decrement with borrow, plus a zero flag on the result.
// Zero latency; an all-zero input yields all-zero rather than wrapping to 99:59.
module mmss_dec
   import timer_pkg::*;
(
   input  mmss_t cur,
   output mmss_t nxt,
   output logic  zero
);

   always_comb begin
      nxt = cur;
      if (is_zero(cur)) begin
         nxt = '0;
      end else if (cur.sec_units != digit_t'(0)) begin
         nxt.sec_units = cur.sec_units - digit_t'(1);
      end else begin
         nxt.sec_units = BCD_MAX;
         // Seconds tens above 5 (e.g. 99 entered) simply count down; wrap only from 0.
         if (cur.sec_tens != digit_t'(0)) begin
            nxt.sec_tens = cur.sec_tens - digit_t'(1);
         end else begin
            nxt.sec_tens = SEC_TENS_WRAP;
            if (cur.min_units != digit_t'(0)) begin
               nxt.min_units = cur.min_units - digit_t'(1);
            end else begin
               nxt.min_units = BCD_MAX;
               nxt.min_tens  = cur.min_tens - digit_t'(1);
            end
         end
      end
      zero = is_zero(nxt);
   end

endmodule

// File: rtl/microwave_timer.sv
// Microwave MM:SS keypad-loaded countdown timer with IDLE/RUN/PAUSE/DONE control.
// Events act on the edge where they are first sampled; outputs registered; no backpressure.
module microwave_timer
   import timer_pkg::*;
(
   input  logic         clk,
   input  logic         clearn,
   input  logic [3:0]   D,
   input  logic         loadn,
   input  logic         pgt_1hz,
   input  logic         startn,
   input  logic         stopn,
   input  logic         door_closed,
   output logic [3:0]   min_tens,
   output logic [3:0]   min_units,
   output logic [3:0]   sec_tens,
   output logic [3:0]   sec_units,
   output logic         running,
   output logic         done
);

   logic   prev_loadn;
   logic   prev_startn;
   logic   prev_stopn;
   logic   prev_tick;
   state_t state;
   mmss_t  cnt;
   mmss_t  cnt_dec;
   logic   dec_zero;

   logic   load_ev;
   logic   start_ev;
   logic   stop_ev;
   logic   tick_ev;
   logic   key_ok;

   assign load_ev  = prev_loadn  & ~loadn;
   assign start_ev = prev_startn & ~startn;
   assign stop_ev  = prev_stopn  & ~stopn;
   assign tick_ev  = ~prev_tick  & pgt_1hz;
   assign key_ok   = (D <= BCD_MAX);

   mmss_dec u_dec (
      .cur  (cnt),
      .nxt  (cnt_dec),
      .zero (dec_zero)
   );

   assign min_tens  = cnt.min_tens;
   assign min_units = cnt.min_units;
   assign sec_tens  = cnt.sec_tens;
   assign sec_units = cnt.sec_units;

   always_ff @(posedge clk) begin
      if (!clearn) begin
         // Previous values start at the idle level so nothing fires right after reset.
         prev_loadn  <= 1'b1;
         prev_startn <= 1'b1;
         prev_stopn  <= 1'b1;
         prev_tick   <= 1'b1;
         state       <= IDLE;
         cnt         <= '0;
         running     <= 1'b0;
         done        <= 1'b0;
      end else begin
         prev_loadn  <= loadn;
         prev_startn <= startn;
         prev_stopn  <= stopn;
         prev_tick   <= pgt_1hz;

         case (state)
            IDLE: begin
               if (stop_ev) begin
                  state <= IDLE;
               end else if (start_ev && door_closed && !is_zero(cnt)) begin
                  state   <= RUN;
                  running <= 1'b1;
               end else if (load_ev && key_ok) begin
                  cnt <= '{cnt.min_units, cnt.sec_tens, cnt.sec_units, D};
               end
            end

            RUN: begin
               if (stop_ev || !door_closed) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end else if (tick_ev) begin
                  cnt <= cnt_dec;
                  if (dec_zero) begin
                     state   <= DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end

            PAUSE: begin
               if (stop_ev) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (start_ev && door_closed) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end

            DONE: begin
               if (stop_ev || !door_closed || start_ev) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end else if (load_ev && key_ok) begin
                  cnt   <= '{4'd0, 4'd0, 4'd0, D};
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end

            default: begin
               state   <= IDLE;
               running <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
